// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and next-PC selection for the MIPS core.
// Two-phase step per instruction: FETCH (memory req/ack) then ISSUE (decode
// and redirect select). Define FETCH_ALIGN_CHECK_EN to trap misaligned JR
// targets into a sticky ERROR state. Without it, JR targets are word-aligned
// by dropping the low bits, and misalign_err reads 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch,
  input  logic [2:0]  branch_type,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken,
  output logic [31:0] retired_cnt,
  output logic        misalign_err
);

  // Branch type encodings from the decoder
  localparam logic [2:0] BT_BEQ  = 3'd0;
  localparam logic [2:0] BT_BNE  = 3'd1;
  localparam logic [2:0] BT_BLTZ = 3'd2;
  localparam logic [2:0] BT_BGEZ = 3'd3;
  localparam logic [2:0] BT_BLEZ = 3'd4;
  localparam logic [2:0] BT_BGTZ = 3'd5;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_ISSUE = 2'd1, S_ERROR = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_ISSUE = 2'd1} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ret_q, ret_d;

  logic        cond;
  logic        redirect;
  logic        err_fire;
  logic        retire;
  logic        fetch_fire;
  logic [31:0] next_pc;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;

  assign pc_plus4  = pc_q + 32'd4;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign retired_cnt = ret_q;

  assign br_tgt = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_tgt  = {pc_plus4[31:28], instr_q[25:0], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  // Misaligned targets never reach the PC; they divert to ERROR instead.
  assign jr_tgt   = rs_val;
  assign err_fire = instr_valid && !stall && jr && (rs_val[1:0] != 2'b00);
`else
  assign jr_tgt   = {rs_val[31:2], 2'b00};
  assign err_fire = 1'b0;
`endif

  // Signed branch condition evaluation; codes 6 and 7 are never taken
  always_comb begin
    cond = 1'b0;
    case (branch_type)
      BT_BEQ:  cond = (rs_val == rt_val);
      BT_BNE:  cond = (rs_val != rt_val);
      BT_BLTZ: cond = rs_val[31];
      BT_BGEZ: cond = !rs_val[31];
      BT_BLEZ: cond = rs_val[31] || (rs_val == 32'd0);
      BT_BGTZ: cond = !rs_val[31] && (rs_val != 32'd0);
      default: cond = 1'b0;
    endcase
  end

  // Next-PC priority: JR, then J, then taken branch, then fall-through
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (jr) begin
      next_pc  = jr_tgt;
      redirect = 1'b1;
    end else if (jump) begin
      next_pc  = j_tgt;
      redirect = 1'b1;
    end else if (branch && cond) begin
      next_pc  = br_tgt;
      redirect = 1'b1;
    end
  end

  assign taken      = instr_valid && redirect;
  assign fetch_fire = (state_q == S_FETCH) && imem_ack;
  assign retire     = instr_valid && !stall && !err_fire;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (imem_ack) state_d = S_ISSUE;
      S_ISSUE: begin
        if (!stall) begin
          if (err_fire) begin
`ifdef FETCH_ALIGN_CHECK_EN
            state_d = S_ERROR;
`endif
          end else begin
            state_d = S_FETCH;
          end
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_ERROR: state_d = S_ERROR;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_FETCH: imem_req    = 1'b1;
      S_ISSUE: instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: capture fetched word, advance PC and count on retire
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    if (fetch_fire) instr_d = imem_rdata;
    if (retire) begin
      pc_d  = next_pc;
      ret_d = ret_q + 32'd1;
    end
  end

  // Datapath registers; reset discards any in-flight fetch data
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ret_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q;

  // Sticky misaligned-JR flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)           mis_q <= 1'b0;
    else if (err_fire) mis_q <= 1'b1;
  end

  assign misalign_err = mis_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, branches, jumps,
// memory wait and stall timing, PC wrap and the JR alignment behaviour.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch;
  logic [2:0]  branch_type;
  logic        jump;
  logic        jr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        taken;
  logic [31:0] retired_cnt;
  logic        misalign_err;

  int total;
  int bad;
  int nret;

  localparam logic [31:0] ADDI = 32'h2008_0005;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .branch(branch), .branch_type(branch_type),
    .jump(jump), .jr(jr), .rs_val(rs_val), .rt_val(rt_val),
    .taken(taken), .retired_cnt(retired_cnt), .misalign_err(misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word to memory and take the FETCH edge; ends in ISSUE
  task automatic issue(input logic [31:0] word);
    imem_rdata = word;
    imem_ack   = 1'b1;
    tick();
  endtask

  // ISSUE edge with stall low
  task automatic retire();
    tick();
    nret++;
  endtask

  task automatic clr();
    branch = 1'b0; branch_type = 3'd0; jump = 1'b0; jr = 1'b0;
    rs_val = 32'd0; rt_val = 32'd0; stall = 1'b0;
  endtask

  initial begin
    logic [2:0]  tab [0:5];
    logic [31:0] vals [0:2];
    logic [31:0] epc;
    logic        t;

    // taken expectations per type (BLTZ..7), bit k for rs = vals[k]
    tab[0] = 3'b001; tab[1] = 3'b110; tab[2] = 3'b011;
    tab[3] = 3'b100; tab[4] = 3'b000; tab[5] = 3'b000;
    vals[0] = 32'hFFFF_FFFF; vals[1] = 32'h0; vals[2] = 32'h1;

    total = 0; bad = 0; nret = 0;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    clr();

    tick();
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_ret", retired_cnt, 0);
    chk("rst_instr", instr, 0);
    chk("rst_mis", misalign_err, 0);

    // reset with ack high discards the data
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rstack_instr", instr, 0);
    chk("rstack_valid", instr_valid, 0);
    chk("rstack_pc", pc, 0);
    rst = 1'b0;

    // sequential ADDIs
    issue(ADDI);
    chk("addi_valid", instr_valid, 1);
    chk("addi_instr", instr, ADDI);
    chk("addi_taken", taken, 0);
    chk("addi_req", imem_req, 0);
    retire();
    chk("addi_pc4", pc, 32'h4);
    chk("addi_valid0", instr_valid, 0);
    issue(ADDI); retire();
    chk("addi_pc8", pc, 32'h8);
    chk("addi_ret2", retired_cnt, 2);
    issue(ADDI); retire();
    issue(ADDI); retire();
    chk("pc10", pc, 32'h10);

    // BEQ taken backwards
    issue(32'h1000_FFFC);
    branch = 1'b1; branch_type = 3'd0; rs_val = 32'd7; rt_val = 32'd7; #1;
    chk("beq_taken", taken, 1);
    retire(); clr();
    chk("beq_addr", imem_addr, 32'h4);

    // back to 0x10 via JR
    issue(ADDI);
    jr = 1'b1; rs_val = 32'h10; #1;
    chk("jr_taken", taken, 1);
    retire(); clr();
    chk("jr_pc10", pc, 32'h10);

    // BEQ not taken
    issue(32'h1000_FFFC);
    branch = 1'b1; branch_type = 3'd0; rs_val = 32'd7; rt_val = 32'd8; #1;
    chk("beq_nt_taken", taken, 0);
    retire(); clr();
    chk("beq_nt_addr", imem_addr, 32'h14);

    // zero-compare branches and unused codes, imm = 1 (target = pc+8)
    epc = 32'h14;
    for (int b = 2; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        issue(32'h0000_0001);
        branch = 1'b1; branch_type = 3'(b); rs_val = vals[k]; #1;
        t = tab[b-2][k];
        chk($sformatf("bt%0d_v%0d_taken", b, k), taken, 32'(t));
        retire(); clr();
        epc = epc + (t ? 32'd8 : 32'd4);
        chk($sformatf("bt%0d_v%0d_pc", b, k), pc, epc);
      end
    end
    chk("ret_after_br", retired_cnt, nret);

    // J within region
    issue(ADDI);
    jr = 1'b1; rs_val = 32'h1000_0000; #1;
    retire(); clr();
    chk("pc_1000", pc, 32'h1000_0000);
    issue(32'h0800_0040);
    jump = 1'b1; #1;
    chk("j_taken", taken, 1);
    retire(); clr();
    chk("j_pc", pc, 32'h1000_0100);

    // JR beats J
    issue(32'h0800_0040);
    jump = 1'b1; jr = 1'b1; rs_val = 32'h200; #1;
    chk("jrj_taken", taken, 1);
    retire(); clr();
    chk("jrj_pc", pc, 32'h200);

    // 3 memory wait cycles, fetch, 2 stall cycles, retire on cycle 7
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wait%0d_req", i), imem_req, 1);
      chk($sformatf("wait%0d_addr", i), imem_addr, 32'h200);
    end
    imem_ack = 1'b1; imem_rdata = ADDI;
    tick();
    chk("wait_issue", instr_valid, 1);
    stall = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    chk("stall_valid", instr_valid, 1);
    chk("stall_instr", instr, ADDI);
    chk("stall_pc", pc, 32'h200);
    chk("stall_ret", retired_cnt, nret);
    stall = 1'b0;
    retire();
    chk("stall_done_pc", pc, 32'h204);
    chk("stall_done_ret", retired_cnt, nret);

    // PC wrap
    issue(ADDI);
    jr = 1'b1; rs_val = 32'hFFFF_FFFC; #1;
    retire(); clr();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    issue(ADDI); retire();
    chk("wrap_pc0", pc, 32'h0);

    // misaligned JR
    issue(ADDI);
    jr = 1'b1; rs_val = 32'h202; #1;
    chk("mis_taken", taken, 1);
`ifdef FETCH_ALIGN_CHECK_EN
    tick(); clr();
    chk("mis_flag", misalign_err, 1);
    chk("mis_req", imem_req, 0);
    chk("mis_valid", instr_valid, 0);
    chk("mis_pc", pc, 32'h0);
    chk("mis_ret", retired_cnt, nret);
    tick(); tick();
    chk("mis_req_hold", imem_req, 0);
    chk("mis_flag_hold", misalign_err, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mis_rst_flag", misalign_err, 0);
    chk("mis_rst_req", imem_req, 1);
`else
    retire(); clr();
    chk("mis_pc", pc, 32'h200);
    chk("mis_flag", misalign_err, 0);
`endif

    // reset while in ISSUE
    issue(ADDI);
    chk("pre_rst_valid", instr_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("issue_rst_pc", pc, 32'h0);
    chk("issue_rst_ret", retired_cnt, 0);
    chk("issue_rst_valid", instr_valid, 0);
    chk("issue_rst_instr", instr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
